// File: rtl/io_port_responder.sv
// Memory-mapped IO responder: debounced buttons, switch snapshot, LED register
// and the ready/ack status flags that polling software uses.
module io_port_responder #(
    parameter int DB_CYCLES = 1_000_000,
    parameter int DB_W      = 20
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pRead,
    input  logic        pWrite,
    input  logic [1:0]  addr,
    input  logic [11:0] writeData,
    output logic [31:0] readData,
    input  logic        btnL,
    input  logic        btnR,
    input  logic [15:0] switch,
    output logic [11:0] led
);

    localparam logic [DB_W-1:0] CNT_LAST = DB_W'(DB_CYCLES - 1);

    logic [1:0] btn_raw;
    logic [1:0] btn_pulse;

    assign btn_raw = {btnR, btnL};

    // One conditioning chain per button: bit 0 = btnL, bit 1 = btnR.
    for (genvar i = 0; i < 2; i++) begin : g_btn
        logic            meta_q;
        logic            sync_q;
        logic            stable_q;
        logic            pulse_q;
        logic [DB_W-1:0] cnt_q;

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                meta_q   <= 1'b0;
                sync_q   <= 1'b0;
                stable_q <= 1'b0;
                pulse_q  <= 1'b0;
                cnt_q    <= '0;
            end else begin
                meta_q  <= btn_raw[i];
                sync_q  <= meta_q;
                pulse_q <= 1'b0;
                if (sync_q == stable_q) begin
                    cnt_q <= '0;
                end else if (cnt_q == CNT_LAST) begin
                    stable_q <= ~stable_q;
                    cnt_q    <= '0;
                    pulse_q  <= ~stable_q;
                end else begin
                    cnt_q <= cnt_q + DB_W'(1);
                end
            end
        end

        assign btn_pulse[i] = pulse_q;
    end

    logic [11:0] led_q, led_d;
    logic [15:0] sw_hold_q, sw_hold_d;
    logic        sw_ready_q, sw_ready_d;
    logic        led_ready_q, led_ready_d;

    // Flag clears are applied first so a same-cycle button pulse wins.
    always_comb begin
        led_d       = led_q;
        sw_hold_d   = sw_hold_q;
        sw_ready_d  = sw_ready_q;
        led_ready_d = led_ready_q;
        if (pWrite && addr == 2'd3) begin
            led_d       = writeData;
            led_ready_d = 1'b0;
        end
        if (pRead && addr == 2'd2) begin
            sw_ready_d = 1'b0;
        end
        if (btn_pulse[0]) begin
            sw_hold_d  = switch;
            sw_ready_d = 1'b1;
        end
        if (btn_pulse[1]) begin
            led_ready_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            led_q       <= '0;
            sw_hold_q   <= '0;
            sw_ready_q  <= 1'b0;
            led_ready_q <= 1'b0;
        end else begin
            led_q       <= led_d;
            sw_hold_q   <= sw_hold_d;
            sw_ready_q  <= sw_ready_d;
            led_ready_q <= led_ready_d;
        end
    end

    always_comb begin
        readData = '0;
        case (addr)
            2'd0: readData = {30'b0, sw_ready_q, led_ready_q};
            2'd1: readData = {24'b0, sw_hold_q[15:8]};
            2'd2: readData = {24'b0, sw_hold_q[7:0]};
            2'd3: readData = {20'b0, led_q};
            default: readData = '0;
        endcase
    end

    assign led = led_q;

endmodule

// File: doc/io_port_responder.md
Name: io_port_responder

Overview:
- Responder end of the memory-mapped IO interface. The CPU-side address decoder drives pRead/pWrite, a 2-bit word index, and write data into this block; the block returns read data.
- Owns the board IO: debounced btnL/btnR, a switch snapshot register, the LED register, and a status register that carries the ready/ack handshake the polling software uses.
- Sits between the decoder's IO window (addr[7]=1) and the pins / 7-segment mux.

Parameters:
- DB_CYCLES, 1_000_000, consecutive stable cycles needed before a button level is accepted (10 ms at 100 MHz). Benches use 4.
- DB_W, 20, width of the debounce counters; must satisfy 2^DB_W > DB_CYCLES.

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- pRead  in  1  IO read access qualifier from decoder
- pWrite  in  1  IO write strobe from decoder
- addr  in  2  word index (CPU addr[3:2])
- writeData  in  12  write data (CPU writeData[11:0])
- readData  out  32  read data, combinational from addr
- btnL  in  1  raw button: "switch data valid"
- btnR  in  1  raw button: "LED ready for data"
- switch  in  16  raw switches
- led  out  12  LED/display register

Behaviour:
- Register map by addr:
  - 0 STATUS: read {30'b0, sw_ready, led_ready}
  - 1 SW_HI: read {24'b0, sw_hold[15:8]}
  - 2 SW_LO: read {24'b0, sw_hold[7:0]}
  - 3 LED: read {20'b0, led}; write loads led <= writeData
  - Writes to addr 0-2 are ignored.
- readData:
  - Pure combinational mux on addr, independent of pRead.
  - Zero-extension in every field exactly as listed in the map.
- Reset (reset=0, asynchronous):
  - led=0, sw_hold=0, sw_ready=0, led_ready=0.
  - Sync flops=0, debounced levels=0, counters=0.
  - readData therefore reads 0 for every addr.
- Input conditioning, per button:
  - 2-flop synchronizer.
  - Debounce counter: if the synced input equals the stable level, the counter clears. Otherwise it increments; when it reaches DB_CYCLES-1, the stable level toggles and the counter clears.
  - Rising edge of the stable level gives a 1-cycle pulse.
  - Latency: a clean press held from cycle N gives its pulse at cycle N+2+DB_CYCLES (±1).
  - A glitch shorter than DB_CYCLES produces no pulse.
  - Release produces no pulse.
- Switch snapshot:
  - On a btnL pulse: sw_hold <= switch (raw value, sampled that cycle) and sw_ready <= 1.
  - switch changes without a pulse do not affect sw_hold.
- Handshake flags:
  - sw_ready: set by btnL pulse; cleared by pRead && addr==2, i.e. software reading SW_LO consumes the sample.
  - led_ready: set by btnR pulse; cleared by pWrite && addr==3, i.e. software writing LED acknowledges.
  - Set and clear in the same cycle: set wins (flag=1). For sw_ready, sw_hold also takes the new sample, so no event is lost.
  - A second pulse while a flag is already 1: flag stays 1; sw_hold is overwritten with the new value.
- Simultaneous events: pRead and pWrite together are legal and act independently. Both button pulses in one cycle both take effect.
- Reset mid-debounce or mid-handshake: all state returns to reset values immediately. A button still held after reset release must pass DB_CYCLES stable cycles again; with the stable level starting at 0, this produces a fresh pulse.
- led drives outputs directly from its register; no combinational path from writeData.

Test Plan (DB_CYCLES=4):
1. Reset sequence: assert reset=0 mid-run with led=12'hABC and both flags set → led=0 and STATUS reads 0 in the same cycle, before any clock edge; addr=3 reads 0.
2. Switch handshake: switch=16'h12F0, press btnL for 10 cycles → STATUS=2 after ~6 cycles; SW_HI=32'h12, SW_LO=32'hF0; read SW_LO with pRead=1 → STATUS=0 next cycle.
3. LED handshake: press btnR → STATUS=1; pWrite, addr=3, writeData=12'h5A5 → led=12'h5A5, STATUS=0, LED reads 32'h5A5. pWrite with addr=1 → led unchanged.
4. Bounce rejection: btnL toggling every 2 cycles for 20 cycles, then low → no pulse, STATUS=0, sw_hold unchanged.
5. Collision: arrange a btnL pulse in the same cycle as a pRead of SW_LO with switch=16'h00FF → STATUS bit1 stays 1, SW_LO reads 32'hFF.
6. Held through reset: hold btnR, pulse reset low for 3 cycles → led_ready=0 during reset, then STATUS=1 again ~6 cycles after release.
